hardtanh_sched: RTL and testbench

- Round-robin scheduler that shares one registered HardTanh clip stage among NUM_REQ streaming requesters.
- Each requester presents bursts of 8-bit signed Q1.6 activation samples over a valid/ready interface.
- The scheduler grants one requester at a time, holds the grant for the whole burst, and clips each sample to runtime-configurable bounds.
- It emits results tagged with the requester ID. It sits between layer output buffers and the activation writeback path.

---
 rtl/hardtanh_sched.sv | 179 +++++++++++++++++
 tb/tb_hardtanh_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hardtanh_sched.sv
// Round-robin scheduler sharing one registered HardTanh clip stage among NUM_REQ
// streaming requesters; grants are held per burst and results are tagged with requester ID.
module hardtanh_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [ID_W-1:0]      out_id,
  output logic                 out_last,
  input  logic                 out_ready,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_pos,
  input  logic [7:0]           cfg_neg,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [7:0]      pos_sh_q, pos_sh_d, neg_sh_q, neg_sh_d;
  logic [7:0]      pos_q, pos_d, neg_q, neg_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic            out_last_q, out_last_d;
  logic            cfg_err_q, cfg_err_d;

  logic [NUM_REQ-1:0] rot_valid;
  int              off;
  logic [ID_W-1:0] arb_idx;
  logic            sel_valid, sel_last;
  logic [7:0]      sel_data, clip_data;
  logic            can_take, acc, last_now, cfg_bad;

  // Rotate valids so bit 0 is rr_ptr; lowest set bit is the round-robin winner.
  always_comb begin
    rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    off = 0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (rot_valid[k]) off = k;
    end
    arb_idx = ID_W'((int'(rr_ptr_q) + off) % int'(NUM_REQ));
  end

  assign can_take = !out_valid_q || out_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (ID_W'(i) == gnt_q) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[8*i +: 8];
        req_ready[i] = (state_q == StBurst) && can_take;
      end
    end
  end

  assign acc      = (state_q == StBurst) && sel_valid && can_take;
  assign last_now = sel_last || (beat_cnt_q == CntMax);

  always_comb begin
    if ($signed(sel_data) < $signed(neg_q)) begin
      clip_data = neg_q;
    end else if ($signed(sel_data) > $signed(pos_q)) begin
      clip_data = pos_q;
    end else begin
      clip_data = sel_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          gnt_d   = arb_idx;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_now) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
            rr_ptr_d   = ID_W'((int'(gnt_q) + 1) % int'(NUM_REQ));
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = clip_data;
      out_id_d    = gnt_q;
      out_last_d  = last_now;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Shadow bounds absorb writes anytime; active bounds only follow while idle,
  // using the next shadow value so an idle write reaches the very next burst.
  always_comb begin
    cfg_bad   = cfg_we && ($signed(cfg_neg) > $signed(cfg_pos));
    cfg_err_d = cfg_bad;
    pos_sh_d  = (cfg_we && !cfg_bad) ? cfg_pos : pos_sh_q;
    neg_sh_d  = (cfg_we && !cfg_bad) ? cfg_neg : neg_sh_q;
    pos_d     = (state_q == StIdle) ? pos_sh_d : pos_q;
    neg_d     = (state_q == StIdle) ? neg_sh_d : neg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      pos_sh_q    <= 8'h40;
      neg_sh_q    <= 8'hC0;
      pos_q       <= 8'h40;
      neg_q       <= 8'hC0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      pos_sh_q    <= pos_sh_d;
      neg_sh_q    <= neg_sh_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q == StBurst) || out_valid_q;

endmodule

// File: tb/tb_hardtanh_sched.sv
// Directed bench for hardtanh_sched: per-requester beat tables drive the inputs and
// accepted outputs are collected into queues for comparison against hand-computed values.
module tb_hardtanh_sched;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [8*NR-1:0] req_data;
  logic          out_valid, out_last, out_ready;
  logic [7:0]    out_data;
  logic [1:0]    out_id;
  logic          cfg_we, cfg_err, busy;
  logic [7:0]    cfg_pos, cfg_neg;

  hardtanh_sched #(.NUM_REQ(4), .MAX_BURST(16), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_ready(out_ready), .cfg_we(cfg_we), .cfg_pos(cfg_pos), .cfg_neg(cfg_neg),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] src_mem [NR][32];
  logic       src_lst [NR][32];
  int         src_len [NR];
  int         src_ptr [NR];

  logic [7:0] oq_data [$];
  logic [1:0] oq_id [$];
  logic       oq_last [$];

  logic [NR-1:0] s_ready;
  logic          s_out_valid, s_out_last, s_cfg_err, s_busy;
  logic [7:0]    s_out_data;
  logic [1:0]    s_out_id;

  // One clock: drive from the tables at negedge, sample 1ns before posedge, advance tables.
  task automatic step();
    logic [NR-1:0] acc;
    for (int i = 0; i < NR; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_mem[i][src_ptr[i]];
        req_last[i]        = src_lst[i][src_ptr[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    #4;
    s_ready = req_ready; s_out_valid = out_valid; s_out_data = out_data;
    s_out_id = out_id; s_out_last = out_last; s_cfg_err = cfg_err; s_busy = busy;
    acc = req_valid & req_ready;
    if (out_valid && out_ready) begin
      oq_data.push_back(out_data); oq_id.push_back(out_id); oq_last.push_back(out_last);
    end
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (acc[i]) src_ptr[i]++;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0; src_ptr[i] = 0;
      for (int j = 0; j < 32; j++) begin src_mem[i][j] = 8'h00; src_lst[i][j] = 1'b0; end
    end
    oq_data.delete(); oq_id.delete(); oq_last.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_we = 1'b0; out_ready = 1'b1;
    clear_src();
    step(); step();
    rst = 1'b0;
    oq_data.delete(); oq_id.delete(); oq_last.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_we = 1'b0; out_ready = 1'b0;
    clear_src();
    step(); step();
    checks++;
    if (s_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", s_ready); end
    checks++;
    if ({s_out_valid, s_out_data, s_out_id, s_out_last} !== 12'h000) begin
      errors++;
      $display("FAIL reset_out got v=%b d=%h id=%0d l=%b want all 0",
               s_out_valid, s_out_data, s_out_id, s_out_last);
    end
    checks++;
    if ({s_cfg_err, s_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_err_busy got %b%b want 00", s_cfg_err, s_busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    src_mem[2][0] = 8'h10; src_lst[2][0] = 1'b1; src_len[2] = 1;
    step();
    checks++;
    if ({s_ready, s_busy} !== 5'b00000) begin
      errors++; $display("FAIL basic_idle got ready=%b busy=%b want 0000/0", s_ready, s_busy);
    end
    step();
    checks++;
    if (s_ready !== 4'b0100) begin errors++; $display("FAIL basic_grant got %b want 0100", s_ready); end
    step();
    checks++;
    if ({s_out_valid, s_out_data, s_out_id, s_out_last} !== {1'b1, 8'h10, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL basic_out got v=%b d=%h id=%0d l=%b want v=1 d=10 id=2 l=1",
               s_out_valid, s_out_data, s_out_id, s_out_last);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL basic_rr got %0d want 3", dut.rr_ptr_q); end
  endtask

  task automatic test_clip();
    logic [7:0] in_d [5];
    logic [7:0] exp_d [5];
    int guard = 0;
    in_d  = '{8'h7F, 8'h80, 8'h40, 8'hC0, 8'hE0};
    exp_d = '{8'h40, 8'hC0, 8'h40, 8'hC0, 8'hE0};
    do_reset();
    for (int j = 0; j < 5; j++) begin src_mem[0][j] = in_d[j]; src_lst[0][j] = (j == 4); end
    src_len[0] = 5;
    while (oq_data.size() < 5 && guard < 40) begin step(); guard++; end
    checks++;
    if (oq_data.size() != 5) begin errors++; $display("FAIL clip_count got %0d want 5", oq_data.size()); end
    for (int k = 0; k < 5 && k < oq_data.size(); k++) begin
      checks++;
      if ({oq_id[k], oq_data[k], oq_last[k]} !== {2'd0, exp_d[k], (k == 4)}) begin
        errors++;
        $display("FAIL clip_beat%0d got id=%0d d=%h l=%b want id=0 d=%h l=%b",
                 k, oq_id[k], oq_data[k], oq_last[k], exp_d[k], (k == 4));
      end
    end
  endtask

  task automatic test_round_robin();
    int guard = 0;
    int b, r, j;
    do_reset();
    for (int q = 0; q < NR; q++) begin
      src_len[q] = (q == 0) ? 6 : 3;
      for (int m = 0; m < 6; m++) begin
        src_mem[q][m] = 8'(q * 16 + m); src_lst[q][m] = (m % 3 == 2);
      end
    end
    while (oq_data.size() < 15 && guard < 80) begin step(); guard++; end
    checks++;
    if (oq_data.size() != 15) begin errors++; $display("FAIL rr_count got %0d want 15", oq_data.size()); end
    checks++;
    if (guard != 21) begin errors++; $display("FAIL rr_cycles got %0d want 21", guard); end
    for (int k = 0; k < 15 && k < oq_data.size(); k++) begin
      b = k / 3; r = b % 4; j = (b == 4) ? 3 + k % 3 : k % 3;
      checks++;
      if ({oq_id[k], oq_data[k], oq_last[k]} !== {2'(r), 8'(r * 16 + j), (k % 3 == 2)}) begin
        errors++;
        $display("FAIL rr_beat%0d got id=%0d d=%h l=%b want id=%0d d=%h l=%b",
                 k, oq_id[k], oq_data[k], oq_last[k], r, 8'(r * 16 + j), (k % 3 == 2));
      end
    end
  endtask

  task automatic test_max_burst();
    int guard = 0;
    logic [1:0] eid;
    logic [7:0] ed;
    logic el;
    do_reset();
    for (int m = 0; m < 20; m++) begin src_mem[1][m] = 8'(m + 1); src_lst[1][m] = (m == 19); end
    src_len[1] = 20;
    src_mem[3][0] = 8'h30; src_mem[3][1] = 8'h31; src_lst[3][1] = 1'b1; src_len[3] = 2;
    while (oq_data.size() < 22 && guard < 100) begin step(); guard++; end
    step(); step(); step();
    checks++;
    if (oq_data.size() != 22) begin errors++; $display("FAIL maxb_count got %0d want 22", oq_data.size()); end
    for (int k = 0; k < 22 && k < oq_data.size(); k++) begin
      if (k < 16) begin
        eid = 2'd1; ed = 8'(k + 1); el = (k == 15);
      end else if (k < 18) begin
        eid = 2'd3; ed = 8'(8'h30 + k - 16); el = (k == 17);
      end else begin
        eid = 2'd1; ed = 8'(k - 1); el = (k == 21);
      end
      checks++;
      if ({oq_id[k], oq_data[k], oq_last[k]} !== {eid, ed, el}) begin
        errors++;
        $display("FAIL maxb_beat%0d got id=%0d d=%h l=%b want id=%0d d=%h l=%b",
                 k, oq_id[k], oq_data[k], oq_last[k], eid, ed, el);
      end
    end
  endtask

  task automatic test_config();
    logic [7:0] exp_a [6];
    logic [1:0] ida [6];
    logic [7:0] exp_b [3];
    int guard = 0;
    exp_a = '{8'h30, 8'h40, 8'h30, 8'h30, 8'h20, 8'hE0};
    ida   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    exp_b = '{8'h20, 8'hE0, 8'h18};
    do_reset();
    src_mem[0][0] = 8'h30; src_mem[0][1] = 8'h50; src_mem[0][2] = 8'h30; src_mem[0][3] = 8'h30;
    src_lst[0][3] = 1'b1; src_len[0] = 4;
    src_mem[1][0] = 8'h30; src_mem[1][1] = 8'hD0; src_lst[1][1] = 1'b1; src_len[1] = 2;
    step(); step();
    cfg_we = 1'b1; cfg_pos = 8'h20; cfg_neg = 8'hE0;
    step();
    cfg_we = 1'b0;
    step();
    checks++;
    if (s_cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_good_err got %b want 0", s_cfg_err); end
    while (oq_data.size() < 6 && guard < 40) begin step(); guard++; end
    checks++;
    if (oq_data.size() != 6) begin errors++; $display("FAIL cfg_count got %0d want 6", oq_data.size()); end
    for (int k = 0; k < 6 && k < oq_data.size(); k++) begin
      checks++;
      if ({oq_id[k], oq_data[k]} !== {ida[k], exp_a[k]}) begin
        errors++;
        $display("FAIL cfg_beat%0d got id=%0d d=%h want id=%0d d=%h",
                 k, oq_id[k], oq_data[k], ida[k], exp_a[k]);
      end
    end
    cfg_we = 1'b1; cfg_pos = 8'hF0; cfg_neg = 8'h10;
    step();
    cfg_we = 1'b0;
    step();
    checks++;
    if (s_cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_bad_pulse got %b want 1", s_cfg_err); end
    step();
    checks++;
    if (s_cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_bad_clear got %b want 0", s_cfg_err); end
    clear_src();
    src_mem[2][0] = 8'h30; src_mem[2][1] = 8'hD0; src_mem[2][2] = 8'h18;
    src_lst[2][2] = 1'b1; src_len[2] = 3;
    guard = 0;
    while (oq_data.size() < 3 && guard < 30) begin step(); guard++; end
    checks++;
    if (oq_data.size() != 3) begin errors++; $display("FAIL cfg_b_count got %0d want 3", oq_data.size()); end
    for (int k = 0; k < 3 && k < oq_data.size(); k++) begin
      checks++;
      if ({oq_id[k], oq_data[k]} !== {2'd2, exp_b[k]}) begin
        errors++;
        $display("FAIL cfg_b_beat%0d got id=%0d d=%h want id=2 d=%h", k, oq_id[k], oq_data[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    for (int m = 0; m < 8; m++) begin src_mem[0][m] = 8'(m + 1); src_lst[0][m] = (m == 7); end
    src_len[0] = 8;
    step(); step(); step();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({s_ready, s_out_valid, s_out_data} !== {4'b0000, 1'b1, 8'h02}) begin
        errors++;
        $display("FAIL stall_c%0d got ready=%b v=%b d=%h want 0000/1/02", c, s_ready, s_out_valid, s_out_data);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_src();
    step();
    checks++;
    if ({s_ready, s_out_valid, s_out_data, s_out_id, s_out_last, s_busy} !== 17'h0) begin
      errors++;
      $display("FAIL stall_rst got ready=%b v=%b d=%h id=%0d l=%b busy=%b want all 0",
               s_ready, s_out_valid, s_out_data, s_out_id, s_out_last, s_busy);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_pos = 8'h00; cfg_neg = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_clip();
    test_round_robin();
    test_max_burst();
    test_config();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
